// File: rtl/rtc_bus_arbiter.sv
// Two-port round-robin arbiter driving the multiplexed V3023 RTC bus.
// Ports: clki/rst; req/rw/addr/wdata per port; ADin; AD/CS/WR/RD strobes,
// ADout/ADoe bus drive, ack0/ack1 pulses, rdata, busy.
module rtc_bus_arbiter (
    input  logic       clki,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [7:0] ADin,
    output logic       AD,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic [7:0] ADout,
    output logic       ADoe,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2, ACK} state_t;

    state_t     state;
    logic [4:0] ph;
    logic       ptr;
    logic       sel;
    logic       rw_l;
    logic [7:0] addr_l;
    logic [7:0] wdata_l;
    logic       gnt_any;
    logic       gnt_port;

    // ptr is the port that wins a tie; it flips away from whoever was served.
    always_comb begin
        gnt_any  = req0 | req1;
        gnt_port = (req0 && req1) ? ptr : req1;
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            state   <= IDLE;
            ph      <= 5'd0;
            ptr     <= 1'b0;
            sel     <= 1'b0;
            rw_l    <= 1'b0;
            addr_l  <= 8'h00;
            wdata_l <= 8'h00;
            AD      <= 1'b1;
            CS      <= 1'b1;
            WR      <= 1'b1;
            RD      <= 1'b1;
            ADout   <= 8'hFF;
            ADoe    <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata   <= 8'h00;
            busy    <= 1'b0;
        end else begin
            ph <= ph + 5'd1;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    ph   <= 5'd0;
                    if (gnt_any) begin
                        state   <= ADDR;
                        sel     <= gnt_port;
                        ptr     <= ~gnt_port;
                        rw_l    <= gnt_port ? rw1 : rw0;
                        addr_l  <= gnt_port ? addr1 : addr0;
                        wdata_l <= gnt_port ? wdata1 : wdata0;
                    end
                end
                // ph counts from 0 at cycle 1 of the address phase.
                ADDR: begin
                    busy <= 1'b1;
                    case (ph)
                        5'd0: AD <= 1'b0;
                        5'd1: CS <= 1'b0;
                        5'd2: WR <= 1'b0;
                        5'd3: begin
                            ADout <= addr_l;
                            ADoe  <= 1'b1;
                        end
                        // Release the bus together with WR so the
                        // drive never outlives the write strobe.
                        5'd6: begin
                            WR   <= 1'b1;
                            ADoe <= 1'b0;
                        end
                        5'd7: CS <= 1'b1;
                        5'd8: begin
                            AD    <= 1'b1;
                            ADout <= 8'hFF;
                            state <= GAP1;
                            ph    <= 5'd0;
                        end
                        default: ;
                    endcase
                end
                GAP1: begin
                    busy <= 1'b1;
                    if (ph == 5'd3) begin
                        state <= DATA;
                        ph    <= 5'd0;
                    end
                end
                // ph 0 is cycle 14.
                DATA: begin
                    busy <= 1'b1;
                    case (ph)
                        5'd0: CS <= 1'b0;
                        5'd1: begin
                            if (rw_l) WR <= 1'b0;
                            else      RD <= 1'b0;
                        end
                        5'd2: begin
                            if (rw_l) begin
                                ADout <= wdata_l;
                                ADoe  <= 1'b1;
                            end
                        end
                        5'd5: begin
                            WR   <= 1'b1;
                            RD   <= 1'b1;
                            ADoe <= 1'b0;
                            if (!rw_l) rdata <= ADin;
                        end
                        5'd6: CS <= 1'b1;
                        5'd7: begin
                            ADout <= 8'hFF;
                            state <= GAP2;
                            ph    <= 5'd0;
                        end
                        default: ;
                    endcase
                end
                GAP2: begin
                    busy <= 1'b1;
                    if (ph == 5'd3) begin
                        state <= ACK;
                        ph    <= 5'd0;
                    end
                end
                // Ack shows in cycle 26; IDLE may grant again at cycle 27.
                ACK: begin
                    busy  <= 1'b1;
                    ack0  <= ~sel;
                    ack1  <= sel;
                    state <= IDLE;
                    ph    <= 5'd0;
                end
                default: begin
                    state <= IDLE;
                    ph    <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Randomized bench for rtc_bus_arbiter against a transaction-level model.
// The model tracks grant offset and derives bus levels from phase windows.
module tb_rtc_bus_arbiter;

    logic       clki = 1'b0;
    logic       rst;
    logic       req_a [2];
    logic       rw_a [2];
    logic [7:0] addr_a [2];
    logic [7:0] wdata_a [2];
    logic [7:0] ADin;
    logic       AD, CS, WR, RD, ADoe, ack0, ack1, busy;
    logic [7:0] ADout, rdata;

    always #10 clki = ~clki;

    rtc_bus_arbiter dut (
        .clki(clki), .rst(rst),
        .req0(req_a[0]), .req1(req_a[1]),
        .rw0(rw_a[0]), .rw1(rw_a[1]),
        .addr0(addr_a[0]), .addr1(addr_a[1]),
        .wdata0(wdata_a[0]), .wdata1(wdata_a[1]),
        .ADin(ADin),
        .AD(AD), .CS(CS), .WR(WR), .RD(RD),
        .ADout(ADout), .ADoe(ADoe),
        .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model state
    bit         m_act = 0;
    int         m_off = 0;
    bit         m_sel = 0;
    bit         m_rw = 0;
    bit         m_ptr = 0;
    logic [7:0] m_addr = 0;
    logic [7:0] m_wdata = 0;
    logic [7:0] m_rdata = 0;
    int         grants = 0;
    int         ack_obs = 0;
    int         run = 100;
    bit         auto_drop = 1;
    bit         dropped [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    // {AD,CS,WR,RD,ADoe,busy,ack0,ack1} from the phase windows.
    function automatic logic [7:0] exp_lvl(bit act, int off, bit rw,
                                           bit sel);
        bit ad, cs, wr, rd, oe, bz, ak;
        if (!act) return 8'b1111_0000;
        ad = !(off >= 1 && off <= 8);
        cs = !((off >= 2 && off <= 7) || (off >= 14 && off <= 19));
        wr = !((off >= 3 && off <= 6) || (rw && off >= 15 && off <= 18));
        rd = !(!rw && off >= 15 && off <= 18);
        oe = (off >= 4 && off <= 6) || (rw && off >= 16 && off <= 18);
        bz = off >= 1 && off <= 26;
        ak = off == 26;
        return {ad, cs, wr, rd, oe, bz, ak && !sel, ak && sel};
    endfunction

    // {defined, value}; cycles 7,8,19,20 carry no requirement.
    function automatic logic [8:0] exp_out(bit act, int off, bit rw,
                                           logic [7:0] a, logic [7:0] w);
        if (!act) return {1'b1, 8'hFF};
        if (off >= 4 && off <= 6) return {1'b1, a};
        if (off >= 16 && off <= 18) return {1'b1, rw ? w : 8'hFF};
        if (off == 7 || off == 8 || off == 19 || off == 20)
            return {1'b0, 8'h00};
        return {1'b1, 8'hFF};
    endfunction

    task automatic step();
        logic       r [2];
        logic       w [2];
        logic [7:0] a [2];
        logic [7:0] d [2];
        logic [7:0] din;
        logic       rs;
        logic [8:0] eo;
        int         p;
        for (int i = 0; i < 2; i++) begin
            r[i] = req_a[i];
            w[i] = rw_a[i];
            a[i] = addr_a[i];
            d[i] = wdata_a[i];
        end
        din = ADin;
        rs = rst;
        @(posedge clki);
        cyc++;
        if (rs) begin
            m_act = 0;
            m_ptr = 0;
            m_rdata = 8'h00;
        end else begin
            if (m_act) begin
                m_off++;
                if (m_off == 19 && !m_rw) m_rdata = din;
                if (m_off == 27) m_act = 0;
            end
            if (!m_act && (r[0] || r[1])) begin
                p = (r[0] && r[1]) ? int'(m_ptr) : int'(r[1]);
                m_ptr = (p == 0);
                m_sel = (p == 1);
                m_rw = w[p];
                m_addr = a[p];
                m_wdata = d[p];
                m_act = 1;
                m_off = 0;
                grants++;
            end
        end
        #1;
        chk("levels", {AD, CS, WR, RD, ADoe, busy, ack0, ack1},
            exp_lvl(m_act, m_off, m_rw, m_sel));
        eo = exp_out(m_act, m_off, m_rw, m_addr, m_wdata);
        if (eo[8]) chk("adout", ADout, eo[7:0]);
        chk("rdata", rdata, m_rdata);
        chk("wr_rd_excl", {31'd0, !WR && !RD}, 0);
        chk("oe_gate", {31'd0, ADoe && (WR || CS)}, 0);
        if (rs) run = 100;
        else if (AD && CS && WR && RD) run++;
        else begin
            if (run > 0) chk("gap", {31'd0, run >= 5}, 1);
            run = 0;
        end
        ack_obs += int'(ack0) + int'(ack1);
        dropped[0] = 0;
        dropped[1] = 0;
        if (m_act && m_off == 26 && auto_drop) begin
            req_a[m_sel] = 1'b0;
            dropped[m_sel] = 1;
        end
    endtask

    initial begin
        int t_ack [$];
        int p_ack [$];
        int n;
        int g0;
        int a0;
        int k;
        rst = 1;
        ADin = 8'h00;
        for (int i = 0; i < 2; i++) begin
            req_a[i] = 0;
            rw_a[i] = 0;
            addr_a[i] = 8'h00;
            wdata_a[i] = 8'h00;
        end
        repeat (3) step();
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_busy", {31'd0, busy}, 0);
        rst = 0;
        step();

        // Single write on port 0
        req_a[0] = 1; rw_a[0] = 1; addr_a[0] = 8'h02; wdata_a[0] = 8'h08;
        for (int i = 0; i < 29; i++) begin
            step();
            if (i == 5)
                chk("w_addr_ph", {AD, CS, WR, ADoe, ADout},
                    {4'b0001, 8'h02});
            if (i == 17)
                chk("w_data_ph", {AD, WR, ADoe, ADout}, {3'b101, 8'h08});
            if (i == 26) chk("w_ack0", {ack1, ack0}, 2'b01);
            if (i == 27) chk("w_busy_drop", {31'd0, busy}, 0);
        end

        // Single read on port 1
        req_a[1] = 1; rw_a[1] = 0; addr_a[1] = 8'h10; ADin = 8'h5A;
        for (int i = 0; i < 29; i++) begin
            step();
            if (i == 16) chk("r_rd_low", {RD, ADoe, WR}, 3'b001);
            if (i == 19) chk("r_rdata", rdata, 8'h5A);
            if (i == 26) chk("r_ack1", {ack1, ack0}, 2'b10);
        end

        // Contention from reset, both held
        rst = 1;
        req_a[0] = 1; rw_a[0] = 1; addr_a[0] = 8'h20; wdata_a[0] = 8'hA0;
        req_a[1] = 1; rw_a[1] = 1; addr_a[1] = 8'h21; wdata_a[1] = 8'hA1;
        auto_drop = 0;
        step();
        rst = 0;
        for (int i = 0; i < 86; i++) begin
            step();
            if (ack0 || ack1) begin
                t_ack.push_back(cyc);
                p_ack.push_back(int'(ack1));
            end
        end
        chk("ct_count", t_ack.size(), 3);
        if (t_ack.size() >= 3) begin
            chk("ct_order", {p_ack[0][1:0], p_ack[1][1:0], p_ack[2][1:0]},
                6'b00_01_00);
            chk("ct_space1", t_ack[1] - t_ack[0], 27);
            chk("ct_space2", t_ack[2] - t_ack[1], 27);
        end
        req_a[0] = 0;
        req_a[1] = 0;
        auto_drop = 1;
        k = 0;
        while (m_act && k < 40) begin
            step();
            k++;
        end
        chk("ct_drain", {31'd0, m_act}, 0);

        // Reset in cycle 5 of a write
        req_a[0] = 1; rw_a[0] = 1; addr_a[0] = 8'h33; wdata_a[0] = 8'h44;
        repeat (6) step();
        rst = 1;
        step();
        chk("rst_abort", {AD, CS, WR, ADoe, ack0, ADout},
            {5'b11100, 8'hFF});
        rst = 0;
        addr_a[0] = 8'h55; wdata_a[0] = 8'h66;
        n = 0;
        for (int i = 0; i < 29; i++) begin
            step();
            if (i == 5) chk("rst_regrant", ADout, 8'h55);
            n += int'(ack0);
        end
        chk("rst_one_ack", n, 1);

        // Random traffic with protocol checks every cycle
        g0 = grants;
        a0 = ack_obs;
        k = 0;
        while (grants - g0 < 1000 && k < 60000) begin
            step();
            k++;
            ADin = 8'($urandom);
            for (int p = 0; p < 2; p++) begin
                if (dropped[p]) continue;
                if (!req_a[p]) begin
                    if (grants - g0 < 1000 && $urandom_range(3) == 0) begin
                        req_a[p] = 1;
                        rw_a[p] = 1'($urandom_range(1));
                        addr_a[p] = 8'($urandom);
                        wdata_a[p] = 8'($urandom);
                    end
                end else if (m_act && int'(m_sel) == p &&
                             m_off >= 1 && m_off <= 25) begin
                    if ($urandom_range(7) == 0) begin
                        rw_a[p] = 1'($urandom_range(1));
                        addr_a[p] = 8'($urandom);
                        wdata_a[p] = 8'($urandom);
                    end
                    if ($urandom_range(63) == 0) req_a[p] = 0;
                end
            end
        end
        chk("rand_budget", {31'd0, k < 60000}, 1);
        k = 0;
        while ((m_act || req_a[0] || req_a[1]) && k < 300) begin
            step();
            k++;
        end
        chk("rand_drain", {31'd0, k < 300}, 1);
        chk("ack_per_grant", ack_obs - a0, grants - g0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
